decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//  Registered, parametrised instruction-decode pipeline stage for each core: fetch -> decode_stage -> execute.
//  Accepts instructions on a valid/ready handshake and holds them in a 2-entry skid buffer.
//  Emits decoded fields and control signals from a register; latency is 1 cycle.
//  Adds over the combinational decoder: mask-based branch resolution, an illegal-opcode flag, flush, backpressure.
// PARAMETERS
//  REG_ADDR_W  4  register-address width; the register file has 2**REG_ADDR_W entries
//  IMM_W       8  immediate width; must be <= 2*REG_ADDR_W
//  INSTR_W     4+3*REG_ADDR_W  instruction width (derived; do not override)
// PORTS
//  clk             in   1           clock, rising edge
//  reset           in   1           reset, synchronous, active-high
//  flush           in   1           synchronous discard of all buffered instructions
//  in_valid        in   1           in_instr is valid
//  in_ready        out  1           the stage accepts in_instr this cycle
//  in_instr        in   INSTR_W     opcode[INSTR_W-1-:4] | rd | rs | rt
//  nzp_stored      in   3           core NZP flags, sampled when the instruction is accepted
//  out_valid       out  1           decoded entry is valid
//  out_ready       in   1           execute consumes the entry
//  out_rd/rs/rt    out  REG_ADDR_W  register-address fields
//  out_imm         out  IMM_W       in_instr[IMM_W-1:0]
//  out_nzp         out  3           top 3 bits of the rd field
//  out_reg_we, out_mem_re, out_mem_we, out_nzp_we, out_ret, out_branch_taken  out 1  controls
//  out_reg_mux     out  2           00 ALU, 01 memory, 10 immediate
//  out_alu_op      out  2           00 add, 01 sub, 10 mul, 11 div
//  out_illegal     out  1           the opcode is undefined
//  wb_valid        in   1           writeback retires a register write (used only with the macro)
//  wb_rd           in   REG_ADDR_W  register being retired
// BEHAVIOUR
//  Opcode map: 0 NOP, 1 BR, 2 CMP, 3 ADD, 4 SUB, 5 MUL, 6 DIV, 7 LDR, 8 STR, 9 CONST, F RET.
//  Opcodes A-E: every enable 0, out_illegal=1, all fields still output.
//  Fields are extracted for every opcode. Control signals default to 0 and are set per opcode:
//   ADD..DIV: reg_we=1, reg_mux=00, alu_op = opcode-3.
//   LDR: reg_we=1, mem_re=1, reg_mux=01.
//   CONST: reg_we=1, reg_mux=10.
//   STR: mem_we=1.   CMP: nzp_we=1.   RET: ret=1.
//  BR: branch_taken = |(nzp_stored & instr_nzp), using nzp_stored at the accept cycle. 000 is never taken.
//  Buffer states:
//   EMPTY: out_valid=0, in_ready=1. Accept -> ONE.
//   ONE: out_valid=1, in_ready=1.
//    accept & !consume -> FULL (new entry goes to the skid register)
//    accept & consume  -> ONE (new entry goes to the output register)
//    consume alone     -> EMPTY
//   FULL: out_valid=1, in_ready=0. Consume -> ONE; the skid entry moves to the output.
//  in_ready is a registered signal (!FULL); the only exception is the scoreboard term under the macro.
//  Outputs are stable while out_valid & !out_ready.
//  Reset, or flush in any state: next state EMPTY and all out_* = 0.
//   An in_valid in the same cycle is dropped.
//   A consume in the same cycle still completes.
//  Reset value: every output 0 except in_ready=1.
// CONFIGURATION
//  DECODE_SCOREBOARD_EN defined:
//   - busy[2**REG_ADDR_W] bit vector.
//   - Set: busy[rd] is set when an instruction with reg_we is accepted.
//   - Clear: busy[wb_rd] is cleared on wb_valid. Set wins if the same register is set and cleared in one cycle.
//   - Hazard: in_ready is also forced 0 when in_valid and any used source or rd is busy.
//     rs and rt are sources for ADD..DIV, CMP and STR; rs only for LDR; the rd check covers WAW.
//   - Reset or flush clears all busy bits.
//  Undefined: wb_* are ignored and in_ready depends only on buffer state.
// STRUCTURE
//  Package decode_pkg holds:
//   - opcode_e enum, reg_mux_e and alu_op_e;
//   - the decoded_t struct (all out_* fields);
//   - the function decode_fn(instr, nzp) -> decoded_t.
//  Sub-module decode_scoreboard holds the busy vector and hazard logic; it is instantiated only under the macro.
// TESTING
//  1. ADD 0x3123, out_ready=1 -> next cycle out_valid=1, rd=1, rs=2, rt=3, reg_we=1, alu_op=00.
//  2. BR 0x1400 with nzp_stored=010 -> branch_taken=1. BR 0x1800 with nzp_stored=010 -> branch_taken=0.
//  3. Hold out_ready=0 and offer 3 instructions -> 2 accepted, in_ready=0.
//     Release out_ready -> entries drain in order and the 3rd is accepted.
//  4. Opcode 0xA000 -> out_illegal=1, all enables 0. 0xF000 -> out_ret=1.
//  5. Flush with FULL buffer and in_valid=1 -> next cycle out_valid=0, in_ready=1, input dropped.
//  6. With macro: LDR rd=5, then ADD rs=5 -> in_ready=0 until wb_valid with wb_rd=5; the ADD is accepted the following cycle.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and the per-opcode decode function for decode_stage.
// Field widths used by decoded_t come from the localparams below.
package decode_pkg;

    localparam int unsigned RegAddrW = 4;
    localparam int unsigned ImmW     = 8;
    localparam int unsigned InstrW   = 4 + 3 * RegAddrW;

    typedef enum logic [3:0] {
        OpNop   = 4'h0,
        OpBr    = 4'h1,
        OpCmp   = 4'h2,
        OpAdd   = 4'h3,
        OpSub   = 4'h4,
        OpMul   = 4'h5,
        OpDiv   = 4'h6,
        OpLdr   = 4'h7,
        OpStr   = 4'h8,
        OpConst = 4'h9,
        OpRet   = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {MuxAlu = 2'b00, MuxMem = 2'b01, MuxImm = 2'b10} reg_mux_e;

    typedef enum logic [1:0] {AluAdd, AluSub, AluMul, AluDiv} alu_op_e;

    typedef struct packed {
        logic [RegAddrW-1:0] rd;
        logic [RegAddrW-1:0] rs;
        logic [RegAddrW-1:0] rt;
        logic [ImmW-1:0]     imm;
        logic [2:0]          nzp;
        logic                reg_we;
        logic                mem_re;
        logic                mem_we;
        logic                nzp_we;
        logic                ret;
        logic                branch_taken;
        reg_mux_e            reg_mux;
        alu_op_e             alu_op;
        logic                illegal;
    } decoded_t;

    function automatic decoded_t decode_fn(input logic [InstrW-1:0] instr,
                                           input logic [2:0]        nzp_stored);
        decoded_t d;
        d       = '0;
        d.rd    = instr[3*RegAddrW-1 -: RegAddrW];
        d.rs    = instr[2*RegAddrW-1 -: RegAddrW];
        d.rt    = instr[RegAddrW-1:0];
        d.imm   = instr[ImmW-1:0];
        d.nzp   = d.rd[RegAddrW-1 -: 3];
        case (opcode_e'(instr[InstrW-1 -: 4]))
            OpNop:   ;
            OpBr:    d.branch_taken = |(nzp_stored & d.nzp);
            OpCmp:   d.nzp_we = 1'b1;
            OpAdd:   begin d.reg_we = 1'b1; d.alu_op = AluAdd; end
            OpSub:   begin d.reg_we = 1'b1; d.alu_op = AluSub; end
            OpMul:   begin d.reg_we = 1'b1; d.alu_op = AluMul; end
            OpDiv:   begin d.reg_we = 1'b1; d.alu_op = AluDiv; end
            OpLdr:   begin d.reg_we = 1'b1; d.mem_re = 1'b1; d.reg_mux = MuxMem; end
            OpStr:   d.mem_we = 1'b1;
            OpConst: begin d.reg_we = 1'b1; d.reg_mux = MuxImm; end
            OpRet:   d.ret = 1'b1;
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Register busy tracking and RAW/WAW hazard detection for decode_stage.
// Only instantiated when DECODE_SCOREBOARD_EN is defined.
module decode_scoreboard
    import decode_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = RegAddrW
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  set_i,
    input  logic [REG_ADDR_W-1:0] set_rd_i,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  chk_valid_i,
    input  opcode_e               chk_op_i,
    input  logic [REG_ADDR_W-1:0] chk_rd_i,
    input  logic [REG_ADDR_W-1:0] chk_rs_i,
    input  logic [REG_ADDR_W-1:0] chk_rt_i,
    output logic                  hazard_o
);

    localparam int unsigned NumRegs = 2 ** REG_ADDR_W;

    logic [NumRegs-1:0] busy_q, busy_d;
    logic use_rs, use_rt, use_rd;

    // Set is applied after clear so a same-cycle set on the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid_i) busy_d[wb_rd_i] = 1'b0;
        if (set_i)      busy_d[set_rd_i] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) busy_q <= '0;
        else                    busy_q <= busy_d;
    end

    always_comb begin
        use_rs = 1'b0;
        use_rt = 1'b0;
        use_rd = 1'b0;
        case (chk_op_i)
            OpAdd, OpSub, OpMul, OpDiv: begin use_rs = 1'b1; use_rt = 1'b1; use_rd = 1'b1; end
            OpCmp, OpStr:               begin use_rs = 1'b1; use_rt = 1'b1; end
            OpLdr:                      begin use_rs = 1'b1; use_rd = 1'b1; end
            OpConst:                    use_rd = 1'b1;
            default:                    ;
        endcase
    end

    assign hazard_o = chk_valid_i & ((use_rs & busy_q[chk_rs_i]) |
                                     (use_rt & busy_q[chk_rt_i]) |
                                     (use_rd & busy_q[chk_rd_i]));

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with a 2-entry skid buffer, flush and backpressure.
// Define DECODE_SCOREBOARD_EN to add register-busy hazard stalls on in_ready_o.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = RegAddrW,
    parameter int unsigned IMM_W      = ImmW,
    parameter int unsigned INSTR_W    = 4 + 3 * REG_ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [INSTR_W-1:0]    in_instr_i,
    input  logic [2:0]            nzp_stored_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [REG_ADDR_W-1:0] out_rd_o,
    output logic [REG_ADDR_W-1:0] out_rs_o,
    output logic [REG_ADDR_W-1:0] out_rt_o,
    output logic [IMM_W-1:0]      out_imm_o,
    output logic [2:0]            out_nzp_o,
    output logic                  out_reg_we_o,
    output logic                  out_mem_re_o,
    output logic                  out_mem_we_o,
    output logic                  out_nzp_we_o,
    output logic                  out_ret_o,
    output logic                  out_branch_taken_o,
    output logic [1:0]            out_reg_mux_o,
    output logic [1:0]            out_alu_op_o,
    output logic                  out_illegal_o,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e   state_q;
    decoded_t out_q, skid_q, dec;
    logic     out_valid_q, in_ready_q;
    logic     accept, consume;

    assign dec     = decode_fn(in_instr_i, nzp_stored_i);
    assign accept  = in_valid_i & in_ready_o;
    assign consume = out_valid_q & out_ready_i;

`ifdef DECODE_SCOREBOARD_EN
    logic hazard;

    decode_scoreboard #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .flush_i    (flush_i),
        .set_i      (accept & dec.reg_we),
        .set_rd_i   (dec.rd),
        .wb_valid_i (wb_valid_i),
        .wb_rd_i    (wb_rd_i),
        .chk_valid_i(in_valid_i),
        .chk_op_i   (opcode_e'(in_instr_i[INSTR_W-1 -: 4])),
        .chk_rd_i   (dec.rd),
        .chk_rs_i   (dec.rs),
        .chk_rt_i   (dec.rt),
        .hazard_o   (hazard)
    );

    assign in_ready_o = in_ready_q & ~hazard;
`else
    logic unused_wb;
    assign unused_wb  = ^{wb_valid_i, wb_rd_i};
    assign in_ready_o = in_ready_q;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            state_q     <= StEmpty;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        out_q       <= dec;
                        out_valid_q <= 1'b1;
                        state_q     <= StOne;
                    end
                end
                StOne: begin
                    if (accept && !consume) begin
                        skid_q     <= dec;
                        in_ready_q <= 1'b0;
                        state_q    <= StFull;
                    end else if (accept && consume) begin
                        out_q <= dec;
                    end else if (consume) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StEmpty;
                    end
                end
                StFull: begin
                    if (consume) begin
                        out_q      <= skid_q;
                        in_ready_q <= 1'b1;
                        state_q    <= StOne;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= StEmpty;
                end
            endcase
        end
    end

    assign out_valid_o        = out_valid_q;
    assign out_rd_o           = out_q.rd;
    assign out_rs_o           = out_q.rs;
    assign out_rt_o           = out_q.rt;
    assign out_imm_o          = out_q.imm;
    assign out_nzp_o          = out_q.nzp;
    assign out_reg_we_o       = out_q.reg_we;
    assign out_mem_re_o       = out_q.mem_re;
    assign out_mem_we_o       = out_q.mem_we;
    assign out_nzp_we_o       = out_q.nzp_we;
    assign out_ret_o          = out_q.ret;
    assign out_branch_taken_o = out_q.branch_taken;
    assign out_reg_mux_o      = out_q.reg_mux;
    assign out_alu_op_o       = out_q.alu_op;
    assign out_illegal_o      = out_q.illegal;

endmodule
